calc_t_arb: RTL and testbench
=============================

// Module: calc_t_arb
// PURPOSE
//   Shares one calc_t transmission pipeline between NCH requester channels (e.g. per-tile dehaze lanes).
//   Arbitrates accepted requests round-robin and issues at most one per cycle to calc_t.
//   Tags each in-flight op with its channel and steers the inv_t result into that channel's response FIFO.
//   calc_t has no backpressure; per-channel credits guarantee no FIFO overflow.
// PARAMETERS
//   NCH    3  number of requester channels (2..8)
//   LAT    6  calc_t latency: ct_in_valid cycle -> ct_out_valid cycle
//   FDEPTH 4  per-channel response FIFO depth (power of 2, >=2)
// PORTS
//   clk          in   1         clock
//   rst_n        in   1         asynchronous active-low reset
//   req_valid    in   NCH       channel i has an operand set
//   req_ready    out  NCH       channel i operand accepted this cycle
//   req_sh       in   NCH*12    S_H per channel, Q0.12, ch i at [12i+11:12i]
//   req_sd       in   NCH*12    S_D per channel, Q0.12
//   req_k        in   NCH*12    K_Hn125 per channel, Q4.8
//   ct_S_H       out  12        to calc_t S_H
//   ct_S_D       out  12        to calc_t S_D
//   ct_K         out  12        to calc_t K_Hn125
//   ct_in_valid  out  1         to calc_t in_valid
//   ct_inv_t     in   12        from calc_t inv_t, Q4.8
//   ct_out_valid in   1         from calc_t out_valid
//   rsp_valid    out  NCH       channel i FIFO non-empty
//   rsp_ready    in   NCH       channel i pops head
//   rsp_data     out  NCH*12    FIFO head per channel, Q4.8
//   busy         out  1         any op in flight or any FIFO non-empty
//   err_orphan   out  1         sticky: ct_out_valid seen with no valid tag
// BEHAVIOUR
//   Reset: ct_* = 0, ct_in_valid = 0, req_ready = 0, rsp_valid = 0, busy = 0, err_orphan = 0.
//   Reset also sets credit[i] = FDEPTH, empties FIFOs, clears the tag pipe and sets rr_ptr = 0.
//   Reset mid-operation drops all in-flight results; calc_t shares rst_n and is flushed too.
//   Eligible: e[i] = req_valid[i] && credit[i] != 0.
//   Grant: the first eligible channel scanning rr_ptr, rr_ptr+1, ..., wrapping mod NCH.
//     - req_ready is one-hot (or zero) and combinational from req_valid and credit.
//     - On a grant to g, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
//   Issue is registered. The edge that accepts g loads ct_S_H/ct_S_D/ct_K with channel g's operands.
//     - The same edge sets ct_in_valid = 1 and writes tag {1, g} into tag pipe stage 0.
//     - With no grant, ct_in_valid <= 0, the ct_* data holds and a tag bubble {0, x} is shifted in.
//   Tag pipe: LAT stages, shifts every clock unconditionally. The last stage aligns with ct_out_valid.
//   Result: ct_out_valid && last tag valid writes ct_inv_t into FIFO[tag.ch].
//     - rsp_valid[ch] rises the next cycle.
//     - ct_out_valid with an invalid last tag sets err_orphan; the data is discarded.
//   Credit[i]: -1 on grant i, +1 on pop i (rsp_valid && rsp_ready); both in one cycle -> unchanged.
//     - Credit counts free FIFO slots minus in-flight ops, so a FIFO write never finds FIFO full.
//   FIFO: log2(FDEPTH)+1-bit read/write pointers, wrap naturally.
//     - Full = MSBs differ and LSBs equal; empty = pointers equal.
//     - Write and pop in the same cycle at any fill level are both honoured.
//     - rsp_data is the registered head and is stable while rsp_valid && !rsp_ready.
//   Throughput: 1 issue/cycle aggregate. A lone channel with FDEPTH <= LAT stalls after FDEPTH issues until a pop.
//   Ordering: results within a channel return in request order; across channels, in grant order.
//   busy = |tag_valid || any FIFO non-empty || ct_in_valid.
// TESTING
//   1. Latency: ch0 req at cycle 0 (S_H=0x400, S_D=0x800, K=0x100) -> ct_in_valid @1, ct_out_valid @7, rsp_valid[0] @8.
//      rsp_data[0] equals the calc_t golden model.
//   2. Round-robin: all 3 channels valid continuously, rsp_ready=1 -> grant order 0,1,2,0,1,2; ct_in_valid high every cycle.
//   3. Credit stall: ch1 only, rsp_ready[1]=0 -> exactly FDEPTH=4 grants, req_ready[1]=0 afterwards, no FIFO overflow.
//      Then one pop -> exactly one further grant.
//   4. Simultaneous grant and pop on the same channel with credit=1 -> credit stays 1; FIFO data order preserved over 100 random ops.
//   5. Reset asserted with 4 ops in flight -> all outputs 0 next cycle; no rsp_valid after release; credits back to FDEPTH.
//   6. Force ct_out_valid=1 with an empty tag pipe -> err_orphan=1 and stays 1 until reset; no FIFO written.

Source files
------------

// File: rtl/calc_t_arb.sv
// -----------------------------------------------------------------------------
// calc_t_arb
//   Shares one calc_t transmission pipeline between NCH requester channels.
//   Requests are arbitrated round-robin, at most one is issued per cycle, and
//   every issued op carries a channel tag down a pipe that tracks calc_t's
//   latency. Each returning inv_t is steered into that channel's response
//   FIFO. calc_t cannot be stalled, so per-channel credits (free FIFO slots
//   minus ops in flight) keep any channel from issuing more than it can hold.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-channel request handshake (ready is one-hot)
//   req_sh/req_sd/req_k     per-channel operands, 12 bits each, ch i at [12i+:12]
//   ct_S_H/ct_S_D/ct_K      registered operands to calc_t
//   ct_in_valid             registered issue strobe to calc_t
//   ct_inv_t/ct_out_valid   result from calc_t, LAT cycles after ct_in_valid
//   rsp_valid/rsp_ready     per-channel response FIFO handshake
//   rsp_data                per-channel FIFO head, ch i at [12i+:12]
//   busy                    ops in flight or any response waiting
//   err_orphan              sticky: a calc_t result arrived without a tag
// -----------------------------------------------------------------------------
module calc_t_arb #(
  parameter int NCH    = 3,
  parameter int LAT    = 6,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*12-1:0] req_sh,
  input  logic [NCH*12-1:0] req_sd,
  input  logic [NCH*12-1:0] req_k,
  output logic [11:0]       ct_S_H,
  output logic [11:0]       ct_S_D,
  output logic [11:0]       ct_K,
  output logic              ct_in_valid,
  input  logic [11:0]       ct_inv_t,
  input  logic              ct_out_valid,
  output logic [NCH-1:0]    rsp_valid,
  input  logic [NCH-1:0]    rsp_ready,
  output logic [NCH*12-1:0] rsp_data,
  output logic              busy,
  output logic              err_orphan
);

  localparam int AW = $clog2(FDEPTH);      // FIFO address bits
  localparam int PW = $clog2(NCH);         // channel index bits
  localparam int CW = $clog2(FDEPTH + 1);  // credit counter bits

  logic [CW-1:0] r_credit [NCH];
  logic [PW-1:0] r_rr_ptr;
  // Stage 0 is concurrent with ct_in_valid; stage LAT is concurrent with
  // ct_out_valid for the same op, hence LAT+1 entries.
  logic [LAT:0]  r_tag_v;
  logic [PW-1:0] r_tag_ch [LAT+1];
  logic [AW:0]   r_wr_ptr [NCH];
  logic [AW:0]   r_rd_ptr [NCH];
  logic [11:0]   r_mem    [NCH][FDEPTH];
  logic          r_err_orphan;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_gnt_oh;
  logic           w_gnt_any;
  logic [PW-1:0]  w_gnt_ch;
  logic           w_wr_en;
  logic [PW-1:0]  w_wr_ch;
  logic           w_orphan;
  int             w_scan_idx;

  // ---------------------------------------------------------------------------
  // Round-robin grant: first eligible channel starting at r_rr_ptr.
  // NOTE: every signal driven here gets a default before the loop, so no path
  // leaves it unassigned and no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_ch   = '0;
    w_scan_idx = 0;
    for (int k = 0; k < NCH; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NCH) w_scan_idx = w_scan_idx - NCH;
      if (!w_gnt_any && w_elig[w_scan_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = PW'(w_scan_idx);
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_gnt_any) w_gnt_oh[w_gnt_ch] = 1'b1;
  end

  // Held low while reset is asserted so no handshake is reported then.
  assign req_ready = rst_n ? w_gnt_oh : '0;

  // Per-channel eligibility, FIFO status and head.
  always_comb begin
    w_elig    = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_elig[i]          = req_valid[i] && (r_credit[i] != '0);
      rsp_valid[i]       = (r_wr_ptr[i] != r_rd_ptr[i]);
      rsp_data[12*i +: 12] = r_mem[i][r_rd_ptr[i][AW-1:0]];
    end
  end

  assign w_pop    = rsp_valid & rsp_ready;
  assign w_wr_en  = ct_out_valid & r_tag_v[LAT];
  assign w_wr_ch  = r_tag_ch[LAT];
  assign w_orphan = ct_out_valid & ~r_tag_v[LAT];

  // ---------------------------------------------------------------------------
  // Issue register and tag pipe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_S_H      <= '0;
      ct_S_D      <= '0;
      ct_K        <= '0;
      ct_in_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_tag_v     <= '0;
      for (int k = 0; k <= LAT; k++) r_tag_ch[k] <= '0;
    end else begin
      ct_in_valid <= w_gnt_any;
      // Shifts every clock; a cycle without a grant inserts a bubble.
      r_tag_v     <= {r_tag_v[LAT-1:0], w_gnt_any};
      r_tag_ch[0] <= w_gnt_ch;
      for (int k = 1; k <= LAT; k++) r_tag_ch[k] <= r_tag_ch[k-1];
      if (w_gnt_any) begin
        ct_S_H   <= req_sh[12*w_gnt_ch +: 12];
        ct_S_D   <= req_sd[12*w_gnt_ch +: 12];
        ct_K     <= req_k [12*w_gnt_ch +: 12];
        r_rr_ptr <= (w_gnt_ch == PW'(NCH - 1)) ? '0 : w_gnt_ch + 1'b1;
      end
    end
  end

  // Credits, FIFO pointers and the orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_orphan <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_credit[i] <= CW'(FDEPTH);
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
    end else begin
      r_err_orphan <= r_err_orphan | w_orphan;
      for (int i = 0; i < NCH; i++) begin
        if (w_gnt_oh[i] && !w_pop[i])      r_credit[i] <= r_credit[i] - 1'b1;
        else if (!w_gnt_oh[i] && w_pop[i]) r_credit[i] <= r_credit[i] + 1'b1;
        if (w_wr_en && (w_wr_ch == PW'(i))) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])                       r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries
  // are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ch][r_wr_ptr[w_wr_ch][AW-1:0]] <= ct_inv_t;
  end

  assign busy       = (|r_tag_v) | (|rsp_valid) | ct_in_valid;
  assign err_orphan = r_err_orphan;

endmodule

// File: tb/tb_calc_t_arb.sv
// -----------------------------------------------------------------------------
// tb_calc_t_arb
//   Directed bench for calc_t_arb with a stand-in calc_t (fixed LAT-cycle
//   pipe computing (S_H ^ S_D) + K). A negedge monitor records every grant's
//   expected result per channel and checks every popped response in order.
// -----------------------------------------------------------------------------
module tb_calc_t_arb;

  localparam int NCH    = 3;
  localparam int LAT    = 6;
  localparam int FDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_ready;
  logic [NCH*12-1:0] req_sh = '0;
  logic [NCH*12-1:0] req_sd = '0;
  logic [NCH*12-1:0] req_k  = '0;
  logic [11:0]       ct_S_H, ct_S_D, ct_K;
  logic              ct_in_valid;
  logic [11:0]       ct_inv_t;
  logic              ct_out_valid;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH-1:0]    rsp_ready = '0;
  logic [NCH*12-1:0] rsp_data;
  logic              busy;
  logic              err_orphan;
  logic              force_ov = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  calc_t_arb #(.NCH(NCH), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sh      (req_sh),
    .req_sd      (req_sd),
    .req_k       (req_k),
    .ct_S_H      (ct_S_H),
    .ct_S_D      (ct_S_D),
    .ct_K        (ct_K),
    .ct_in_valid (ct_in_valid),
    .ct_inv_t    (ct_inv_t),
    .ct_out_valid(ct_out_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] golden(input logic [11:0] sh, sd, k);
    return (sh ^ sd) + k;
  endfunction

  // Stand-in calc_t: exactly LAT cycles from ct_in_valid to ct_out_valid.
  logic        m_v [LAT];
  logic [11:0] m_d [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        m_v[k] <= 1'b0;
        m_d[k] <= '0;
      end
    end else begin
      m_v[0] <= ct_in_valid;
      m_d[0] <= golden(ct_S_H, ct_S_D, ct_K);
      for (int k = 1; k < LAT; k++) begin
        m_v[k] <= m_v[k-1];
        m_d[k] <= m_d[k-1];
      end
    end
  end
  assign ct_out_valid = m_v[LAT-1] | force_ov;
  assign ct_inv_t     = m_d[LAT-1];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: expected responses per channel in grant order.
  logic [11:0] exp_q [NCH][$];
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) exp_q[c].delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (req_ready[c])
          exp_q[c].push_back(golden(req_sh[12*c +: 12], req_sd[12*c +: 12], req_k[12*c +: 12]));
        if (rsp_valid[c] && rsp_ready[c]) begin
          if (exp_q[c].size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else                      check("rsp_data_order", 32'(rsp_data[12*c +: 12]), 32'(exp_q[c].pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    force_ov  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = '1;
    repeat (n) tick();
    rsp_ready = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_gr;
    logic seen;

    // ---- reset state ----
    #2;
    check("rst_ct_in_valid", 32'(ct_in_valid), 32'd0);
    check("rst_req_ready",   32'(req_ready),   32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_err_orphan",  32'(err_orphan),  32'd0);
    check("rst_ct_data",     32'({ct_S_H, ct_S_D, ct_K}), 32'd0);
    do_reset();

    // ---- 1: latency ----
    req_sh[11:0] = 12'h400;
    req_sd[11:0] = 12'h800;
    req_k[11:0]  = 12'h100;
    req_valid    = 3'b001;
    #1 check("t1_req_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    #1;
    check("t1_ct_in_valid", 32'(ct_in_valid), 32'd1);
    check("t1_ct_S_H", 32'(ct_S_H), 32'h400);
    check("t1_ct_S_D", 32'(ct_S_D), 32'h800);
    check("t1_ct_K",   32'(ct_K),   32'h100);
    check("t1_busy",   32'(busy),   32'd1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c <= 7) begin
        check("t1_ct_out_valid", 32'(ct_out_valid), (c == 7) ? 32'd1 : 32'd0);
        check("t1_rsp_valid_early", 32'(rsp_valid), 32'd0);
      end else begin
        check("t1_rsp_valid", 32'(rsp_valid), 32'b001);
        check("t1_rsp_data",  32'(rsp_data[11:0]), 32'hD00);
      end
    end
    rsp_ready = 3'b001;
    tick();
    rsp_ready = '0;
    tick();
    check("t1_empty_after_pop", 32'(rsp_valid), 32'd0);

    // ---- 2: round-robin ----
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      req_sh[12*c +: 12] = 12'(12'h111 * (c + 1));
      req_sd[12*c +: 12] = 12'(12'h0F0 + c);
      req_k [12*c +: 12] = 12'(12'h020 * (c + 1));
    end
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      #1 check("t2_grant_order", 32'(req_ready), 32'(1 << (k % NCH)));
      tick();
      check("t2_ct_in_valid", 32'(ct_in_valid), 32'd1);
    end
    drain(12);
    check("t2_idle", 32'(busy), 32'd0);

    // ---- 3: credit stall ----
    req_valid = 3'b010;
    n_gr = 0;
    for (int k = 0; k < 12; k++) begin
      #1 n_gr += int'(req_ready[1]);
      tick();
    end
    check("t3_grants", 32'(n_gr), 32'd4);
    check("t3_ready_low", 32'(req_ready), 32'd0);
    check("t3_fifo_valid", 32'(rsp_valid), 32'b010);
    rsp_ready = 3'b010;
    n_gr = 0;
    #1 n_gr += int'(req_ready[1]);
    tick();
    rsp_ready = '0;
    for (int k = 0; k < 9; k++) begin
      #1 n_gr += int'(req_ready[1]);
      tick();
    end
    check("t3_grant_after_pop", 32'(n_gr), 32'd1);
    drain(15);

    // ---- 4: simultaneous grant and pop at credit 1 ----
    req_valid = 3'b100;
    repeat (3) tick();
    req_valid = '0;
    repeat (10) tick();
    req_valid = 3'b100;
    rsp_ready = 3'b100;
    #1;
    check("t4_grant_with_pop", 32'(req_ready), 32'b100);
    check("t4_pop_valid", 32'(rsp_valid[2]), 32'd1);
    tick();
    rsp_ready = '0;
    #1 check("t4_credit_one_left", 32'(req_ready), 32'b100);
    tick();
    #1 check("t4_credit_exhausted", 32'(req_ready), 32'd0);
    drain(15);

    // 100 random ops with random backpressure
    n_gr = 0;
    for (int cyc = 0; cyc < 2000 && n_gr < 100; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        req_sh[12*c +: 12] = 12'($urandom);
        req_sd[12*c +: 12] = 12'($urandom);
        req_k [12*c +: 12] = 12'($urandom);
      end
      req_valid = NCH'($urandom);
      rsp_ready = NCH'($urandom);
      #1 n_gr += $countones(req_ready);
      tick();
    end
    check("t4_rand_grants", 32'(n_gr >= 100), 32'd1);
    drain(25);
    check("t4_idle", 32'(busy), 32'd0);
    for (int c = 0; c < NCH; c++) check("t4_all_returned", 32'(exp_q[c].size()), 32'd0);

    // ---- 5: reset with ops in flight ----
    req_valid = '1;
    rsp_ready = '1;
    repeat (4) tick();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_ct_in_valid", 32'(ct_in_valid), 32'd0);
    check("t5_ct_data",     32'({ct_S_H, ct_S_D, ct_K}), 32'd0);
    check("t5_req_ready",   32'(req_ready), 32'd0);
    check("t5_rsp_valid",   32'(rsp_valid), 32'd0);
    check("t5_busy",        32'(busy), 32'd0);
    check("t5_err_orphan",  32'(err_orphan), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen |= |rsp_valid;
    end
    check("t5_no_rsp_after_reset", 32'(seen), 32'd0);
    rsp_ready = '0;
    req_valid = 3'b001;
    n_gr = 0;
    for (int k = 0; k < 12; k++) begin
      #1 n_gr += int'(req_ready[0]);
      tick();
    end
    check("t5_credits_restored", 32'(n_gr), 32'd4);
    drain(15);

    // ---- 6: orphan result ----
    check("t6_idle", 32'(busy), 32'd0);
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    #1 check("t6_err_orphan_set", 32'(err_orphan), 32'd1);
    repeat (5) tick();
    check("t6_err_orphan_sticky", 32'(err_orphan), 32'd1);
    check("t6_no_fifo_write", 32'(rsp_valid), 32'd0);
    do_reset();
    #1 check("t6_err_orphan_cleared", 32'(err_orphan), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
